// File: rtl/dff_counter_multimode.sv
// Parametrised multi-mode counter: binary up/down modulo MAX_COUNT+1, Johnson and ring,
// with enable, synchronous load, automatic reseed on mode change and a cascadable carry.
module dff_counter_multimode #(
    parameter int          WIDTH     = 4,
    parameter int unsigned MAX_COUNT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    typedef enum logic [1:0] {
        MODE_UP      = 2'b00,
        MODE_DOWN    = 2'b01,
        MODE_JOHNSON = 2'b10,
        MODE_RING    = 2'b11
    } mode_e;

    // Bad parameters are rejected at elaboration rather than producing a silently wrong counter.
    if (WIDTH < 2 || WIDTH > 32) begin : gWidthCheck
        $fatal(1, "dff_counter_multimode: WIDTH must be within 2..32");
    end
    if (64'(MAX_COUNT) > ((64'd1 << WIDTH) - 64'd1)) begin : gMaxCheck
        $fatal(1, "dff_counter_multimode: MAX_COUNT does not fit in WIDTH bits");
    end

    localparam logic [WIDTH-1:0] MAX_Q    = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] ONE_Q    = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic [WIDTH-1:0] seedOf(input mode_e m);
        logic [WIDTH-1:0] s;
        s = '0;
        case (m)
            MODE_UP:      s = '0;
            MODE_DOWN:    s = MAX_Q;
            MODE_JOHNSON: s = '0;
            MODE_RING:    s = ONE_Q;
            default:      s = '0;
        endcase
        return s;
    endfunction

    mode_e            mode_q;
    mode_e            mode_d;
    mode_e            modeIn;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] countNext;
    logic             reseed;
    logic             terminal;
    logic             binaryMode;

    assign modeIn     = mode_e'(mode);
    assign reseed     = (modeIn != mode_q);
    assign binaryMode = (mode_q == MODE_UP) || (mode_q == MODE_DOWN);

    // Out-of-range binary values fall into the wrap branch so they recover on the next count.
    always_comb begin
        countNext = q_q;
        case (mode_q)
            MODE_UP:      countNext = (q_q >= MAX_Q) ? '0 : (q_q + ONE_Q);
            MODE_DOWN:    countNext = ((q_q == '0) || (q_q > MAX_Q)) ? MAX_Q : (q_q - ONE_Q);
            MODE_JOHNSON: countNext = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
            MODE_RING:    countNext = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            default:      countNext = q_q;
        endcase
    end

    // Priority reseed > load > count > hold; a mode change swallows ld and en for that edge.
    always_comb begin
        mode_d = mode_q;
        q_d    = q_q;
        if (reseed) begin
            mode_d = modeIn;
            q_d    = seedOf(modeIn);
        end else if (ld) begin
            if (binaryMode) begin
                q_d = (d > MAX_Q) ? MAX_Q : d;
            end else begin
                q_d = seedOf(mode_q);
            end
        end else if (en) begin
            q_d = countNext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q    <= '0;
            mode_q <= MODE_UP;
        end else begin
            q_q    <= q_d;
            mode_q <= mode_d;
        end
    end

    always_comb begin
        terminal = 1'b0;
        case (mode_q)
            MODE_UP:      terminal = (q_q == MAX_Q);
            MODE_DOWN:    terminal = (q_q == '0);
            MODE_JOHNSON: terminal = (q_q == MSB_ONLY);
            MODE_RING:    terminal = q_q[WIDTH-1];
            default:      terminal = 1'b0;
        endcase
    end

    // Carry is high only in the cycle whose edge actually wraps the counter, so it can drive the next stage's en.
    assign tc = en & ~ld & ~rst & ~reseed & terminal;
    assign q  = q_q;

endmodule

// File: tb/tb_dff_counter_multimode.sv
// Directed bench: a default 4-bit/15 instance plus a MAX_COUNT=9 pair wired as a two-stage cascade.
module tb_dff_counter_multimode;

    logic       clk;
    logic       rst;
    logic       enA, ldA;
    logic [3:0] dA, qA;
    logic [1:0] modeA;
    logic       tcA;
    logic       enB, ldB;
    logic [3:0] dB, qB;
    logic [1:0] modeB;
    logic       tcB;
    logic [3:0] qC;
    logic [1:0] modeC;
    logic       tcC;
    int         checks;
    int         errors;

    dff_counter_multimode dutA (
        .clk(clk), .rst(rst), .en(enA), .ld(ldA), .d(dA), .mode(modeA), .q(qA), .tc(tcA)
    );

    dff_counter_multimode #(.WIDTH(4), .MAX_COUNT(9)) dutB (
        .clk(clk), .rst(rst), .en(enB), .ld(ldB), .d(dB), .mode(modeB), .q(qB), .tc(tcB)
    );

    dff_counter_multimode #(.WIDTH(4), .MAX_COUNT(9)) dutC (
        .clk(clk), .rst(rst), .en(tcB), .ld(1'b0), .d(4'd0), .mode(modeC), .q(qC), .tc(tcC)
    );

    always #5 clk = ~clk;

    // Inputs change just after a falling edge; checks happen at the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (qA !== 4'd0 || tcA !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_async: q=%0d tc=%0b, expected q=0 tc=0", qA, tcA);
        end
        tick();
        tick();
        checks++;
        if (qA !== 4'd0 || qB !== 4'd0 || qC !== 4'd0 || tcA !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_held: qA=%0d qB=%0d qC=%0d tcA=%0b, expected all 0", qA, qB, qC, tcA);
        end
        rst = 1'b0;
    endtask

    task automatic test_up();
        logic [3:0] expQ;
        checks++;
        if (qA !== 4'd0 || tcA !== 1'b0) begin
            errors++;
            $display("[TB] FAIL up_start: q=%0d tc=%0b, expected q=0 tc=0", qA, tcA);
        end
        for (int i = 1; i <= 16; i++) begin
            tick();
            expQ = 4'(i % 16);
            checks++;
            if (qA !== expQ || tcA !== (expQ == 4'd15)) begin
                errors++;
                $display("[TB] FAIL up_seq step %0d: q=%0d tc=%0b, expected q=%0d tc=%0b",
                         i, qA, tcA, expQ, (expQ == 4'd15));
            end
        end
        ldA = 1'b1;
        dA  = 4'd7;
        tick();
        ldA = 1'b0;
        checks++;
        if (qA !== 4'd7) begin
            errors++;
            $display("[TB] FAIL up_load: q=%0d, expected 7", qA);
        end
    endtask

    task automatic test_down();
        logic [3:0] expQ;
        checks++;
        if (qB !== 4'd0 || tcB !== 1'b0) begin
            errors++;
            $display("[TB] FAIL down_pre_reseed: q=%0d tc=%0b, expected q=0 tc=0", qB, tcB);
        end
        tick();
        checks++;
        if (qB !== 4'd9 || tcB !== 1'b0) begin
            errors++;
            $display("[TB] FAIL down_reseed: q=%0d tc=%0b, expected q=9 tc=0", qB, tcB);
        end
        for (int i = 1; i <= 10; i++) begin
            tick();
            expQ = (i == 10) ? 4'd9 : 4'(9 - i);
            checks++;
            if (qB !== expQ || tcB !== (expQ == 4'd0)) begin
                errors++;
                $display("[TB] FAIL down_seq step %0d: q=%0d tc=%0b, expected q=%0d tc=%0b",
                         i, qB, tcB, expQ, (expQ == 4'd0));
            end
        end
        modeB = 2'b00;
        enB   = 1'b0;
        tick();
        checks++;
        if (qB !== 4'd0) begin
            errors++;
            $display("[TB] FAIL down_to_up_reseed: q=%0d, expected 0", qB);
        end
        ldB = 1'b1;
        dB  = 4'd12;
        tick();
        checks++;
        if (qB !== 4'd9) begin
            errors++;
            $display("[TB] FAIL load_clamp: q=%0d, expected 9", qB);
        end
        dB = 4'd4;
        tick();
        ldB = 1'b0;
        checks++;
        if (qB !== 4'd4) begin
            errors++;
            $display("[TB] FAIL load_in_range: q=%0d, expected 4", qB);
        end
    endtask

    task automatic test_johnson();
        logic [3:0] jseq [8];
        jseq = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
        enA   = 1'b1;
        modeA = 2'b10;
        tick();
        checks++;
        if (qA !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL johnson_reseed: q=%b, expected 0000", qA);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (qA !== jseq[i] || tcA !== (jseq[i] == 4'b1000)) begin
                errors++;
                $display("[TB] FAIL johnson_seq step %0d: q=%b tc=%0b, expected q=%b tc=%0b",
                         i, qA, tcA, jseq[i], (jseq[i] == 4'b1000));
            end
        end
        tick();
        tick();
        tick();
        checks++;
        if (qA !== 4'b0111) begin
            errors++;
            $display("[TB] FAIL johnson_mid: q=%b, expected 0111", qA);
        end
        ldA = 1'b1;
        dA  = 4'b1010;
        tick();
        ldA = 1'b0;
        checks++;
        if (qA !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL johnson_load: q=%b, expected 0000", qA);
        end
    endtask

    task automatic test_ring();
        logic [3:0] rseq [5];
        rseq  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        modeA = 2'b11;
        checks++;
        if (tcA !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ring_pre_reseed_tc: tc=%0b, expected 0", tcA);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (qA !== rseq[i] || tcA !== (rseq[i] == 4'b1000)) begin
                errors++;
                $display("[TB] FAIL ring_seq step %0d: q=%b tc=%0b, expected q=%b tc=%0b",
                         i, qA, tcA, rseq[i], (rseq[i] == 4'b1000));
            end
        end
        tick();
        tick();
        tick();
        enA = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (qA !== 4'b1000 || tcA !== 1'b0) begin
                errors++;
                $display("[TB] FAIL ring_hold cycle %0d: q=%b tc=%0b, expected q=1000 tc=0", i, qA, tcA);
            end
        end
        enA = 1'b1;
    endtask

    task automatic test_mode_switch();
        modeA = 2'b00;
        enA   = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (qA !== 4'd5) begin
            errors++;
            $display("[TB] FAIL switch_setup: q=%0d, expected 5", qA);
        end
        modeA = 2'b11;
        ldA   = 1'b1;
        dA    = 4'd3;
        #1;
        checks++;
        if (tcA !== 1'b0) begin
            errors++;
            $display("[TB] FAIL switch_tc: tc=%0b, expected 0", tcA);
        end
        tick();
        checks++;
        if (qA !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL switch_reseed: q=%b, expected 0001", qA);
        end
        ldA = 1'b0;
    endtask

    task automatic test_cascade();
        int expL;
        int expU;
        for (int i = 1; i <= 25; i++) begin
            tick();
            expL = i % 10;
            expU = i / 10;
            checks++;
            if (qB !== 4'(expL) || qC !== 4'(expU)) begin
                errors++;
                $display("[TB] FAIL cascade step %0d: lower=%0d upper=%0d, expected lower=%0d upper=%0d",
                         i, qB, qC, expL, expU);
            end
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (qB !== 4'd0 || qC !== 4'd0 || qA !== 4'd0 || tcB !== 1'b0) begin
            errors++;
            $display("[TB] FAIL cascade_async_rst: qA=%0d lower=%0d upper=%0d tcB=%0b, expected all 0",
                     qA, qB, qC, tcB);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clk    = 1'b0;
        rst    = 1'b1;
        enA    = 1'b1;
        ldA    = 1'b0;
        dA     = 4'd0;
        modeA  = 2'b00;
        enB    = 1'b1;
        ldB    = 1'b0;
        dB     = 4'd0;
        modeB  = 2'b00;
        modeC  = 2'b00;

        test_reset();
        test_up();
        modeB = 2'b01;
        do_reset();
        test_down();
        test_johnson();
        test_ring();
        test_mode_switch();
        modeB = 2'b00;
        enB   = 1'b1;
        ldB   = 1'b0;
        do_reset();
        test_cascade();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
